// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer.
//   apb_slv_state_t : completer FSM encoding (IDLE, WAIT)
//   ADDR_LSB/IDX_W  : byte-lane and word-index widths for the default geometry
//   is_err()        : misaligned / out-of-range test on a byte address
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } apb_slv_state_t;

  localparam int DEF_STRB_SIZE = 4;
  localparam int DEF_DEPTH     = 16;
  localparam int ADDR_LSB      = $clog2(DEF_STRB_SIZE);
  localparam int IDX_W         = $clog2(DEF_DEPTH);

  // The address is passed zero-extended to 64 bits so the helper works for
  // any bus width up to 64. An access is illegal when the two low address
  // bits are non-zero, or when any bit above the word index is set.
  function automatic logic is_err(input logic [63:0] addr,
                                  input int          addr_width,
                                  input int          addr_lsb,
                                  input int          idx_w);
    logic err;
    err = (addr[1:0] != 2'b00);
    for (int i = 0; i < 64; i++) begin
      if ((i >= addr_lsb + idx_w) && (i < addr_width) && addr[i]) begin
        err = 1'b1;
      end
    end
    return err;
  endfunction

endpackage

// File: rtl/apb_slave_mem.sv
// Register memory behind the APB completer.
//   clk, rst_n : clock and asynchronous active-low clear of every word
//   we         : write enable (one word per cycle)
//   idx        : word index, shared by write and read ports
//   strobe     : per-byte write enables
//   wdata      : write data
//   dout       : combinational read of word idx
module apb_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_SIZE  = DATA_WIDTH / 8,
  parameter int DEPTH      = 16,
  parameter int IDX_BITS   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_BITS-1:0]   idx,
  input  logic [STRB_SIZE-1:0]  strobe,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  // Whole-array clear on reset means this stays in registers rather than
  // block RAM; the read port must be combinational anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_reg[w] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < STRB_SIZE; b++) begin
        if (strobe[b]) begin
          mem_reg[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign dout = mem_reg[idx];

endmodule

// File: rtl/apb_slave.sv
// APB completer with a DEPTH-word byte-strobed register memory.
//   clk, rst_n            : clock, asynchronous active-low reset
//   sel, enable, write    : APB psel / penable / pwrite
//   strobe, addr, wdata   : APB pstrb / paddr / pwdata (latched in setup)
//   rdata                 : read data, non-zero only on a good read completion
//   ready                 : pready, combinational
//   slverr                : pslverr, only together with ready
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_SIZE   = DATA_WIDTH / 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [STRB_SIZE-1:0]  strobe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  slverr
);

  localparam int         LANE_BITS = $clog2(STRB_SIZE);
  localparam int         IDX_BITS  = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  apb_slv_state_t        state_reg,  state_next;
  logic [3:0]            cnt_reg,    cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg,   addr_next;
  logic                  write_reg,  write_next;
  logic [DATA_WIDTH-1:0] wdata_reg,  wdata_next;
  logic [STRB_SIZE-1:0]  strobe_reg, strobe_next;

  logic                  err;
  logic                  mem_we;
  logic [IDX_BITS-1:0]   mem_idx;
  logic [DATA_WIDTH-1:0] mem_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      wdata_reg  <= '0;
      strobe_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      write_reg  <= write_next;
      wdata_reg  <= wdata_next;
      strobe_reg <= strobe_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    write_next  = write_reg;
    wdata_next  = wdata_reg;
    strobe_next = strobe_reg;
    case (state_reg)
      IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray enable is ignored.
        if (sel && !enable) begin
          addr_next   = addr;
          write_next  = write;
          wdata_next  = wdata;
          strobe_next = strobe;
          cnt_next    = WAIT_LOAD;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (!sel) begin
          state_next = IDLE;
        end else if (enable) begin
          if (cnt_reg != 4'd0) begin
            cnt_next = cnt_reg - 4'd1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready   = (state_reg == WAIT) && sel && enable && (cnt_reg == 4'd0);
  assign err     = is_err(64'(addr_reg), ADDR_WIDTH, LANE_BITS, IDX_BITS);
  assign slverr  = ready && err;
  assign mem_idx = addr_reg[LANE_BITS +: IDX_BITS];
  assign mem_we  = ready && write_reg && !err;
  assign rdata   = (ready && !write_reg && !err) ? mem_dout : '0;

  apb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_SIZE  (STRB_SIZE),
    .DEPTH      (DEPTH),
    .IDX_BITS   (IDX_BITS)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_we),
    .idx    (mem_idx),
    .strobe (strobe_reg),
    .wdata  (wdata_reg),
    .dout   (mem_dout)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: three instances (0, 2 and 3 wait states) share the
// bus; each has its own select, so unselected instances just see stray enables.
module tb_apb_slave;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic        enable;
  logic        write;
  logic [3:0]  strobe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata [3];
  logic [2:0]  ready;
  logic [2:0]  slverr;

  int checks   = 0;
  int failures = 0;

  int          wait_cfg [3] = '{0, 2, 3};
  logic [31:0] model [3][16];

  apb_slave #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel[0]), .enable(enable), .write(write),
    .strobe(strobe), .addr(addr), .wdata(wdata), .rdata(rdata[0]),
    .ready(ready[0]), .slverr(slverr[0]));

  apb_slave #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel[1]), .enable(enable), .write(write),
    .strobe(strobe), .addr(addr), .wdata(wdata), .rdata(rdata[1]),
    .ready(ready[1]), .slverr(slverr[1]));

  apb_slave #(.WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sel(sel[2]), .enable(enable), .write(write),
    .strobe(strobe), .addr(addr), .wdata(wdata), .rdata(rdata[2]),
    .ready(ready[2]), .slverr(slverr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void clear_model();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++)
        model[d][w] = 32'h0;
  endfunction

  function automatic logic addr_is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd64);
  endfunction

  // One complete APB transfer on instance d. When chained, the call starts
  // right after the previous completion edge (no idle cycle). When keep is
  // set, sel stays high afterwards so the next call can chain.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input bit chained, input bit keep,
                      output logic [31:0] rd_out);
    int          waits;
    bit          done;
    logic [31:0] got_rd;
    logic        got_err;
    logic        exp_err;
    logic [31:0] exp_rd;
    if (!chained) begin
      @(posedge clk); #1;
    end
    sel = 3'b000; sel[d] = 1'b1; enable = 1'b0;
    write = wr; addr = a; wdata = wd; strobe = st;
    @(negedge clk);
    checks++;
    if (ready[d] !== 1'b0) begin
      failures++;
      $display("FAIL setup_ready dut=%0d got=%b want=0", d, ready[d]);
    end
    @(posedge clk); #1;
    enable = 1'b1;
    addr = $urandom;   // must be ignored: the setup-phase values were latched
    wdata = $urandom;
    waits = 0; done = 0; got_rd = 'x; got_err = 'x;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        got_rd = rdata[d]; got_err = slverr[d]; done = 1;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    exp_err = addr_is_bad(a);
    exp_rd  = (wr || exp_err) ? 32'h0 : model[d][a[5:2]];
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout dut=%0d addr=%h got=no_ready want=ready", d, a);
    end
    checks++;
    if (waits != wait_cfg[d]) begin
      failures++;
      $display("FAIL wait_states dut=%0d got=%0d want=%0d", d, waits, wait_cfg[d]);
    end
    checks++;
    if (got_err !== exp_err) begin
      failures++;
      $display("FAIL slverr dut=%0d addr=%h got=%b want=%b", d, a, got_err, exp_err);
    end
    checks++;
    if (got_rd !== exp_rd) begin
      failures++;
      $display("FAIL rdata dut=%0d addr=%h got=%h want=%h", d, a, got_rd, exp_rd);
    end
    if (wr && !exp_err)
      for (int b = 0; b < 4; b++)
        if (st[b]) model[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
    $display("XFER dut=%0d %s addr=%h wdata=%h strb=%b rdata=%h slverr=%b waits=%0d",
             d, wr ? "WR" : "RD", a, wd, st, got_rd, got_err, waits);
    @(posedge clk); #1;
    enable = 1'b0;
    if (!keep) sel = 3'b000;
    rd_out = got_rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 3'b000; enable = 1'b0; write = 1'b0;
    strobe = 4'h0; addr = 32'h0; wdata = 32'h0;
    clear_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ready[d] !== 1'b0 || slverr[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d got=%b/%b/%h want=0/0/0",
                 d, ready[d], slverr[d], rdata[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, rd);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_read got=%h want=deadbeef", rd);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h4, 32'h11223344, 4'hF, 0, 0, rd);
    xfer(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 0, 0, rd);
    xfer(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'b0000, 0, 0, rd);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 0, rd);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL partial_strobe got=%h want=11bb33dd", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    xfer(2, 1'b1, 32'h0, 32'hCAFE0001, 4'hF, 0, 0, rd);
    xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd);
    xfer(1, 1'b1, 32'h3C, 32'h5A5A5A5A, 4'hF, 0, 0, rd);
    xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, 0, 0, rd);
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, 0, rd);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd);   // word 0 must be untouched
    xfer(0, 1'b0, 32'h2, 32'h0, 4'h0, 0, 0, rd);
    xfer(0, 1'b1, 32'h9, 32'h87654321, 4'hF, 0, 0, rd);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0, rd);
    xfer(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, rd);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++)
        xfer(d, 1'b1, 32'(4 * i), 32'(i + 1), 4'hF, i != 0, 1, rd);
      for (int i = 0; i < 4; i++) begin
        xfer(d, 1'b0, 32'(4 * i), 32'h0, 4'h0, 1, i != 3, rd);
        checks++;
        if (rd !== 32'(i + 1)) begin
          failures++;
          $display("FAIL b2b_read dut=%0d idx=%0d got=%h want=%h", d, i, rd, 32'(i + 1));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    int          kind;
    for (int n = 0; n < 36; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else if (kind == 1) a = 32'h40 + 32'($urandom_range(0, 1023));
      else                a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      xfer(n % 3, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0, 0, rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    bit          saw_ready;
    @(posedge clk); #1;
    sel = 3'b010; enable = 1'b0; write = 1'b1; addr = 32'h0;
    wdata = ~model[1][0]; strobe = 4'hF;
    @(posedge clk); #1;
    enable = 1'b1;
    saw_ready = 0;
    @(negedge clk); if (ready[1] === 1'b1) saw_ready = 1;
    @(posedge clk); #1;
    sel = 3'b000; enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); if (ready[1] === 1'b1) saw_ready = 1;
    end
    checks++;
    if (saw_ready) begin
      failures++;
      $display("FAIL abort_ready got=1 want=0");
    end
    $display("XFER dut=1 WR addr=00000000 aborted");
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd);   // model unchanged
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    xfer(0, 1'b1, 32'h8, 32'hA5A5F00D, 4'hF, 0, 0, rd);
    @(posedge clk); #1;
    sel = 3'b001; enable = 1'b0; write = 1'b0; addr = 32'h8;
    @(posedge clk); #1;
    enable = 1'b1;
    #1;
    checks++;
    if (ready[0] !== 1'b1 || rdata[0] !== 32'hA5A5F00D) begin
      failures++;
      $display("FAIL pre_reset_read got=%b/%h want=1/a5a5f00d", ready[0], rdata[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_access got=%b/%h want=0/00000000", ready[0], rdata[0]);
    end
    $display("XFER dut=0 RD addr=00000008 reset mid-access");
    sel = 3'b000; enable = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      xfer(d, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0, rd);
      xfer(d, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd);
      xfer(d, 1'b0, 32'h3C, 32'h0, 4'h0, 0, 0, rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_strobe();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
